// File: rtl/h14tx_pkt_assembler.sv
// h14tx_pkt_assembler: serialises one HDMI 1.4 data island packet per 32-clock slot with BCH parity.
//   in  clk, rst (async, active-high), enable (payload clocks), packet (packet_t), packet_valid
//   out packet_ready (comb), header_bit (ch0 bit 2), sub_even / sub_odd (ch1 / ch2), abort (pulse)
package h14tx_pkg;
    typedef struct packed {
        logic [23:0]      header;
        logic [3:0][55:0] sub;
    } packet_t;
endpackage

module h14tx_pkt_assembler
    import h14tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  packet_t    packet,
    input  logic       packet_valid,
    output logic       packet_ready,
    output logic       header_bit,
    output logic [3:0] sub_even,
    output logic [3:0] sub_odd,
    output logic       abort
);
    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        ecc_step = (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
    endfunction

    logic [4:0]      k;
    logic            first;
    packet_t         shadow, cur;
    logic [7:0]      eh, eh_nxt;
    logic [3:0][7:0] es, es_nxt;
    logic            hb_nxt;
    logic [3:0]      se_nxt, so_nxt;

    assign first        = k == 5'd0;
    assign packet_ready = enable && first && !rst;
    // slot 0 reads the live input (or the null packet); later slots replay the captured copy
    assign cur          = first ? (packet_valid ? packet : '0) : shadow;

    // parity slots: k 24..31 maps to eh bit k[2:0]; k 28..31 maps to es bit pair k[1:0]
    always_comb begin
        eh_nxt = first ? 8'h00 : eh;
        hb_nxt = eh[k[2:0]];
        if (k < 5'd24) begin
            hb_nxt = cur.header[k];
            eh_nxt = ecc_step(eh_nxt, cur.header[k]);
        end
        for (int i = 0; i < 4; i++) begin
            es_nxt[i] = first ? 8'h00 : es[i];
            se_nxt[i] = es[i][{k[1:0], 1'b0}];
            so_nxt[i] = es[i][{k[1:0], 1'b1}];
            if (k < 5'd28) begin
                se_nxt[i] = cur.sub[i][{k, 1'b0}];
                so_nxt[i] = cur.sub[i][{k, 1'b1}];
                es_nxt[i] = ecc_step(ecc_step(es_nxt[i], se_nxt[i]), so_nxt[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k          <= '0;
            shadow     <= '0;
            eh         <= '0;
            es         <= '0;
            header_bit <= 1'b0;
            sub_even   <= '0;
            sub_odd    <= '0;
            abort      <= 1'b0;
        end else if (!enable) begin
            k          <= '0;
            shadow     <= '0;
            eh         <= '0;
            es         <= '0;
            header_bit <= 1'b0;
            sub_even   <= '0;
            sub_odd    <= '0;
            abort      <= !first;
        end else begin
            k          <= k + 5'd1;
            shadow     <= cur;
            eh         <= eh_nxt;
            es         <= es_nxt;
            header_bit <= hb_nxt;
            sub_even   <= se_nxt;
            sub_odd    <= so_nxt;
            abort      <= 1'b0;
        end
    end
endmodule

// File: doc/h14tx_pkt_assembler.md
# h14tx_pkt_assembler

- Serialises one `packet_t` (24-bit header plus four 56-bit subpackets) into the 32-clock HDMI 1.4 data island bit stream, appending BCH ECC parity.
- Sits directly downstream of the packet generators (AVI/audio InfoFrames, ACR, null) and the packet mux.
- Feeds the TERC4 encoder input of channels 0–2.
- Output is registered; it pulls a new packet at the first clock of every 32-clock packet slot.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  high during data island payload clocks; one packet per 32 clocks, back-to-back allowed
- `packet`  in  `packet_t`  header[23:0], sub[0..3][55:0]
- `packet_valid`  in  1  `packet` holds a packet to send
- `packet_ready`  out  1  combinational; packet is taken this cycle when `packet_valid && packet_ready`
- `header_bit`  out  1  channel 0 data bit 2
- `sub_even`  out  4  channel 1 data bits; bit i = subpacket i even bit
- `sub_odd`  out  4  channel 2 data bits; bit i = subpacket i odd bit
- `abort`  out  1  one-cycle pulse when `enable` falls mid-packet

## Operation
- 5-bit slot counter `k` (0..31).
  - Advances when `enable` is high.
  - Wraps 31 → 0.
  - Cleared when `enable` is low.
- `packet_ready = enable && k == 0`.
- Packet selection at `k == 0`, registered into a shadow register:
  - `packet_valid` high: capture `packet`.
  - `packet_valid` low: capture all zeros, i.e. the null packet (header type 0x00).
- The packet source for slot `k` is `packet` directly at `k == 0` and the shadow register for `k` of 1..31.
- Header, for `k` 0..23:
  - Data bit = `header[k]`, LSB first: byte0 bits 0..7, then byte1, then byte2.
  - Feed that bit into header ECC `eh`.
- Header, for `k` 24..31: emit `eh[k-24]`.
- Subpacket i, for `k` 0..27:
  - even bit = `sub[i][2k]`, odd bit = `sub[i][2k+1]`.
  - Feed the even bit, then the odd bit, into ECC `es[i]`; this is two serial steps per clock.
- Subpacket i, for `k` 28..31: even = `es[i][2(k-28)]`, odd = `es[i][2(k-28)+1]`.
- ECC step, BCH generator 1+x^6+x^7+x^8:
  - `fb = e[0] ^ bit`.
  - `e = (e >> 1) ^ (fb ? 8'h83 : 8'h00)`.
- All five ECC registers are zeroed at `k == 0`, before the first step of the new packet.
- Parity bits are emitted while the ECC register is frozen; no ECC update for `k` ≥ 24 (header) or ≥ 28 (sub).
- Abort: `enable` falls while `k` ≠ 0.
  - `abort` pulses for one cycle.
  - Counter and ECC are cleared.
  - The shadow packet is discarded; the next packet restarts at `k = 0`.

## Timing
- Reset values:
  - `header_bit`, `sub_even`, `sub_odd`, `abort` = 0.
  - `k` = 0, ECCs = 0, shadow = 0.
  - `packet_ready` = 0, since `enable` is irrelevant during reset.
- Latency: the bits for slot `k` appear on the outputs one clock after the `enable` cycle with counter = `k`.
- Outputs are 0 one clock after any cycle with `enable` low.
- Back-to-back packets: `k` goes 31 → 0 with no bubble; the new packet is captured in that same cycle.
- `packet` only needs to be stable in the `packet_ready` cycle.
- Reset asserted mid-packet: all state is cleared immediately; no `abort` pulse.
- `enable` rising with `k == 0` always starts a new slot, whether or not a packet is valid.

## Test plan
- Null slot: `enable` high for 32 clocks, `packet_valid` low.
  - `packet_ready` high only on the first clock.
  - All outputs 0 for clocks 1..32.
- Header ECC: header = 0x0D0282 (AVI InfoFrame v2, length 13), all subs zero.
  - `header_bit` over output clocks 1..24 = LSB-first bits of 0x82, 0x02, 0x0D.
  - Clocks 25..32 = 0xE4, LSB first.
  - `sub_even` and `sub_odd` stay 0.
- Subpacket mapping: `sub[2]` = 56'h1, other fields zero.
  - Output clock 1: `sub_even` = 4'b0100.
  - The 8 parity bits on clocks 29..32 match a bit-serial model (first step 0x83, then 55 zero steps).
- Back-to-back: two random packets over 64 enable clocks.
  - Two `packet_ready` pulses, 32 clocks apart.
  - Bit streams match the reference model with no gap.
- Abort: `enable` drops at `k = 10`.
  - `abort` pulses once.
  - Outputs are 0 the next cycle.
  - Re-enabling pulls a fresh packet at `k = 0`.
- Reset mid-packet at `k = 17`: outputs go to 0 asynchronously, and the next slot starts at `k = 0`.
